// File: rtl/line_scan_sequencer.sv
// rtl/line_scan_sequencer.sv - select/enable sequencer for a 4-to-16 line decoder
// Visits masked lines in ascending order, each for a programmable dwell, with a one-cycle blanking gap.
module line_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        line_mask,
    output logic [3:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [15:0]        mask_q, mask_d;
    logic               mode_q, mode_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               start_go;
    logic [4:0]         next_hit;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] cur);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic logic [DWELL_W-1:0] load_val(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    assign start_go = start && !stop;
    assign next_hit = next_above(mask_q, idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= 16'd0;
            mode_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_go && (line_mask != 16'd0)) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (stop)              state_d = S_IDLE;
                else if (cnt_q == '0)  state_d = S_GAP;
            end
            S_GAP: begin
                if (stop)                       state_d = S_IDLE;
                else if (next_hit[4] || mode_q) state_d = S_ACTIVE;
                else                            state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        en_d    = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    mask_d  = line_mask;
                    dwell_d = dwell;
                    mode_d  = mode_cont;
                    if (line_mask != 16'd0) begin
                        idx_d = lowest_set(line_mask);
                        cnt_d = load_val(dwell);
                        en_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (!stop && (cnt_q != '0)) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                    en_d  = 1'b1;
                end
            end
            S_GAP: begin
                // stop suppresses the next line, the wrap and the done alike.
                if (!stop) begin
                    if (next_hit[4]) begin
                        idx_d = next_hit[3:0];
                        cnt_d = load_val(dwell_q);
                        en_d  = 1'b1;
                    end else if (mode_q) begin
                        idx_d  = lowest_set(mask_q);
                        cnt_d  = load_val(dwell_q);
                        en_d   = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // The decoder wants the line index bit-reversed: sel[0] carries the index MSB.
    assign sel  = {idx_q[0], idx_q[1], idx_q[2], idx_q[3]};
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// tb/tb_line_scan_sequencer.sv - scoreboard bench for line_scan_sequencer
// Stimulus pushes the expected en/done/wrap cycles; a monitor pops and compares them.
module tb_line_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_cont = 1'b0;
    logic [7:0]  dwell = 8'd0;
    logic [15:0] line_mask = 16'd0;
    logic [3:0]  sel;
    logic        en, busy, done, wrap;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic       en;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    logic [3:0] last_sel = 4'd0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    line_scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
        .dwell(dwell), .line_mask(line_mask), .sel(sel), .en(en), .busy(busy),
        .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] rev(input int n);
        logic [3:0] v;
        v = 4'(n);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic void push_exp(input int t, input logic [3:0] s, input logic e,
                                     input logic b, input logic d, input logic w);
        exp_t x;
        x.cyc = t; x.sel = s; x.en = e; x.busy = b; x.done = d; x.wrap = w;
        q.push_back(x);
    endfunction

    // Expected outputs for a scan starting at edge k, truncated after cycle limit.
    function automatic void push_scan(input logic [15:0] m, input int d_in, input bit mode,
                                      input int k, input int limit);
        int d;
        int t;
        bit wr;
        d  = (d_in == 0) ? 1 : d_in;
        t  = k;
        wr = 1'b0;
        if (m == 16'd0) begin
            push_exp(k, last_sel, 1'b0, 1'b0, 1'b1, 1'b0);
            return;
        end
        while (t <= limit) begin
            for (int n = 0; n < 16; n++) begin
                if (m[n]) begin
                    for (int j = 0; j < d; j++) begin
                        if (t <= limit) begin
                            push_exp(t, rev(n), 1'b1, 1'b1, 1'b0, wr && (j == 0));
                            last_sel = rev(n);
                        end
                        t++;
                    end
                    wr = 1'b0;
                    t++;
                end
            end
            if (!mode) begin
                if (t <= limit) push_exp(t, last_sel, 1'b0, 1'b0, 1'b1, 1'b0);
                return;
            end
            wr = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    me = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_output: expected at cyc %0d sel=%b en=%b done=%b wrap=%b, output absent",
                             me.cyc, me.sel, me.en, me.done, me.wrap);
                end
                if (en || done || wrap) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: cyc %0d sel=%b en=%b busy=%b done=%b wrap=%b, none expected",
                                 cyc, sel, en, busy, done, wrap);
                    end else begin
                        me = q.pop_front();
                        if (me.cyc != cyc || me.sel !== sel || me.en !== en || me.busy !== busy ||
                            me.done !== done || me.wrap !== wrap) begin
                            errors++;
                            $display("FAIL scoreboard: got cyc=%0d sel=%b en=%b busy=%b done=%b wrap=%b expected cyc=%0d sel=%b en=%b busy=%b done=%b wrap=%b",
                                     cyc, sel, en, busy, done, wrap,
                                     me.cyc, me.sel, me.en, me.busy, me.done, me.wrap);
                        end
                    end
                end
            end
        end
    endtask

    task automatic do_start(input logic [15:0] m, input logic [7:0] d, input bit mode,
                            input int limit_rel, output int k);
        @(negedge clk);
        line_mask = m;
        dwell     = d;
        mode_cont = mode;
        start     = 1'b1;
        k         = cyc + 1;
        push_scan(m, int'(d), mode, k, k + limit_rel);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic stop_at(input int c, input string name);
        wait_until(c);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        chk({name, "_en"}, int'(en), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        #1;
        chk({name, "_queue_left"}, q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bc;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_sel", int'(sel), 0);
        chk("reset_en", int'(en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wrap", int'(wrap), 0);

        // Full single sweep; inputs changed and start re-pulsed mid-scan must be ignored.
        do_start(16'hFFFF, 8'd3, 1'b0, 100000, k);
        line_mask = 16'h0001;
        dwell     = 8'd7;
        mode_cont = 1'b1;
        bc = 0;
        for (int i = 0; i < 70; i++) begin
            if (busy) bc++;
            start = (i == 10);
            @(negedge clk);
        end
        start = 1'b0;
        chk("sweep_busy_cycles", bc, 64);
        drain("sweep");

        // Continuous 0/5/10/15 with dwell 0; stop lands in the last gap and must beat the wrap.
        do_start(16'h8421, 8'd0, 1'b1, 23, k);
        stop_at(k + 23, "stop_in_gap");
        chk("stop_in_gap_wrap", int'(wrap), 0);
        drain("cont_8421");

        // Stop on the second enable cycle of line 2, then restart from line 0.
        do_start(16'h0015, 8'd4, 1'b1, 6, k);
        stop_at(k + 6, "stop_line2");
        drain("stop_line2");
        do_start(16'h0015, 8'd4, 1'b1, 26, k);
        stop_at(k + 26, "restart");
        drain("restart");

        // Empty mask: done only, sel keeps the last visited line.
        do_start(16'h0000, 8'd5, 1'b0, 100000, k);
        bc = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || en) bc++;
            @(negedge clk);
        end
        chk("empty_busy_en_cycles", bc, 0);
        drain("empty");

        // Single line in continuous mode wraps every period.
        do_start(16'h0100, 8'd2, 1'b1, 10, k);
        stop_at(k + 10, "single_line");
        drain("single_line");

        // Maximum dwell.
        do_start(16'h8000, 8'd255, 1'b0, 100000, k);
        wait_until(k + 258);
        drain("max_dwell");

        // start together with stop in IDLE does nothing.
        @(negedge clk);
        line_mask = 16'hFFFF;
        dwell     = 8'd1;
        start     = 1'b1;
        stop      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("start_stop_busy", int'(busy), 0);
        chk("start_stop_en", int'(en), 0);
        drain("start_stop");

        // Asynchronous reset in the middle of an enable cycle.
        do_start(16'hFFFF, 8'd2, 1'b1, 6, k);
        wait_until(k + 6);
        #1;
        chk("pre_reset_en", int'(en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_en", int'(en), 0);
        chk("async_reset_busy", int'(busy), 0);
        q.delete();
        last_sel = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || en || busy) bc++;
        end
        chk("post_reset_activity", bc, 0);
        chk("post_reset_sel", int'(sel), 0);
        drain("reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
